// File: rtl/imem_boot_controller.sv
// imem_boot_controller: fills the instruction memory from a byte stream while
// holding the core, then releases the core and serves registered fetches on
// the same memory port.
module imem_boot_controller #(
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_load_start,
  input  logic [ADDR_WIDTH:0]   i_load_words,
  input  logic                  i_byte_valid,
  input  logic [7:0]            i_byte_data,
  output logic                  o_byte_ready,
  input  logic                  i_fetch_req,
  input  logic [31:0]           i_fetch_addr,
  output logic                  o_fetch_valid,
  output logic [31:0]           o_fetch_data,
  output logic                  o_fetch_fault,
  output logic                  o_core_hold,
  output logic                  o_load_done,
  output logic [ADDR_WIDTH:0]   o_words_loaded,
  output logic                  o_mem_we,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [31:0]           o_mem_wdata,
  input  logic [31:0]           i_mem_rdata
);

  localparam int unsigned CNT_W     = ADDR_WIDTH + 1;
  localparam int unsigned MEM_WORDS = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_DRAIN = 2'd2,
    S_RUN   = 2'd3
  } state_t;

  state_t                r_state;
  logic                  r_byte_ready;
  logic                  r_mem_we;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [31:0]           r_mem_wdata;
  logic                  r_fetch_valid;
  logic [31:0]           r_fetch_data;
  logic                  r_fetch_fault;
  logic                  r_core_hold;
  logic                  r_load_done;
  logic [CNT_W-1:0]      r_words_loaded;
  logic [CNT_W-1:0]      r_target;
  logic [1:0]            r_byte_cnt;
  logic [23:0]           r_asm;

  logic                  w_start;
  logic [CNT_W-1:0]      w_target;
  logic                  w_byte_fire;
  logic                  w_word_done;
  logic [CNT_W-1:0]      w_words_next;
  logic                  w_last_word;
  logic                  w_fault;

  // Load requests are honoured only when no load is in flight
  assign w_start      = i_load_start && ((r_state == S_IDLE) || (r_state == S_RUN));
  // Requests beyond the memory size saturate to a full-memory load
  assign w_target     = (i_load_words > CNT_W'(MEM_WORDS)) ? CNT_W'(MEM_WORDS) : i_load_words;
  assign w_byte_fire  = (r_state == S_LOAD) && r_byte_ready && i_byte_valid;
  assign w_word_done  = w_byte_fire && (r_byte_cnt == 2'd3);
  assign w_words_next = r_words_loaded + CNT_W'(1);
  assign w_last_word  = w_word_done && (w_words_next == r_target);
  // Misaligned or beyond-memory byte addresses are faulted
  assign w_fault      = (i_fetch_addr[1:0] != 2'b00) || (i_fetch_addr[31:ADDR_WIDTH+2] != '0);

  // Sequencer, stream packer and fetch responder
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state        <= S_IDLE;
      r_byte_ready   <= 1'b0;
      r_mem_we       <= 1'b0;
      r_mem_addr     <= '0;
      r_mem_wdata    <= '0;
      r_fetch_valid  <= 1'b0;
      r_fetch_data   <= '0;
      r_fetch_fault  <= 1'b0;
      r_core_hold    <= 1'b1;
      r_load_done    <= 1'b0;
      r_words_loaded <= '0;
      r_target       <= '0;
      r_byte_cnt     <= 2'd0;
      r_asm          <= '0;
    end else begin
      r_mem_we      <= 1'b0;
      r_load_done   <= 1'b0;
      r_fetch_valid <= 1'b0;

      if (w_start) begin
        // A load request wins over any fetch in the same cycle
        r_target       <= w_target;
        r_words_loaded <= '0;
        r_byte_cnt     <= 2'd0;
        r_mem_addr     <= '0;
        r_core_hold    <= 1'b1;
        if (w_target == '0) begin
          r_state      <= S_DRAIN;
          r_byte_ready <= 1'b0;
          r_load_done  <= 1'b1;
        end else begin
          r_state      <= S_LOAD;
          r_byte_ready <= 1'b1;
        end
      end else begin
        case (r_state)
          S_LOAD: begin
            if (w_word_done) begin
              r_mem_we       <= 1'b1;
              r_mem_addr     <= r_words_loaded[ADDR_WIDTH-1:0];
              r_mem_wdata    <= {i_byte_data, r_asm};
              r_words_loaded <= w_words_next;
              r_byte_cnt     <= 2'd0;
              if (w_last_word) begin
                r_state      <= S_DRAIN;
                r_byte_ready <= 1'b0;
                r_load_done  <= 1'b1;
              end
            end else if (w_byte_fire) begin
              case (r_byte_cnt)
                2'd0:    r_asm[7:0]   <= i_byte_data;
                2'd1:    r_asm[15:8]  <= i_byte_data;
                default: r_asm[23:16] <= i_byte_data;
              endcase
              r_byte_cnt <= r_byte_cnt + 2'd1;
            end
          end
          S_DRAIN: begin
            r_state     <= S_RUN;
            r_core_hold <= 1'b0;
          end
          S_RUN: begin
            if (i_fetch_req) begin
              r_fetch_valid <= 1'b1;
              r_fetch_fault <= w_fault;
              r_fetch_data  <= w_fault ? 32'h0 : i_mem_rdata;
            end
          end
          default: begin
            r_state <= r_state;
          end
        endcase
      end
    end
  end

  // Memory port follows the fetch address in RUN, the write register otherwise
  assign o_mem_addr     = (r_state == S_RUN) ? i_fetch_addr[ADDR_WIDTH+1:2] : r_mem_addr;
  assign o_mem_we       = r_mem_we;
  assign o_mem_wdata    = r_mem_wdata;
  assign o_byte_ready   = r_byte_ready;
  assign o_fetch_valid  = r_fetch_valid;
  assign o_fetch_data   = r_fetch_data;
  assign o_fetch_fault  = r_fetch_fault;
  assign o_core_hold    = r_core_hold;
  assign o_load_done    = r_load_done;
  assign o_words_loaded = r_words_loaded;

endmodule

// File: doc/imem_boot_controller.md
# imem_boot_controller

Sequencer and port owner for the 1024-word instruction memory. After reset it holds the core and fills the memory from a byte stream, such as a UART receiver. The bytes are packed little-endian into 32-bit words and written to consecutive word addresses. Once the load finishes it releases the core and serves registered instruction fetches on the same memory port.

## Interface
- ADDR_WIDTH, 10, word-address width of the instruction memory (1024 words)
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- load_start  in  1  single-cycle request to begin a load; honoured in IDLE or RUN
- load_words  in  ADDR_WIDTH+1  number of words to load; captured with load_start; values above 1024 saturate to 1024
- byte_valid  in  1  stream byte present
- byte_data  in  8  stream byte
- byte_ready  out  1  controller accepts a byte; transfer happens when byte_valid & byte_ready
- fetch_req  in  1  core fetch request
- fetch_addr  in  32  core byte address
- fetch_valid  out  1  registered fetch response strobe
- fetch_data  out  32  registered instruction word
- fetch_fault  out  1  registered; response is for a misaligned or out-of-range address
- core_hold  out  1  core must stall or stay in reset while high
- load_done  out  1  one-cycle pulse at load completion
- words_loaded  out  ADDR_WIDTH+1  count of words written in the current or last load
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_WIDTH  memory word address
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data, combinational from mem_addr

## Operation
- **States:** IDLE, LOAD, DRAIN, RUN.
- **Reset** (rst low, takes effect immediately):
  - state = IDLE, core_hold = 1.
  - byte_ready, mem_we, fetch_valid, fetch_fault, load_done = 0.
  - mem_addr, mem_wdata, fetch_data, words_loaded = 0.
  - Internal byte counter = 0.
- **IDLE:**
  - load_start with load_words != 0 -> LOAD.
  - load_start with load_words == 0 -> DRAIN with no write.
- **LOAD:**
  - byte_ready = 1.
  - Accepted bytes fill lanes in order: byte 0 to bits 7:0, up to byte 3 to bits 31:24.
  - On the 4th byte of word k, the assembled word goes to a write register. Next cycle: mem_we = 1, mem_addr = k, mem_wdata = word, and words_loaded increments.
  - A new byte may be accepted in that same write cycle.
  - When word N-1 completes -> DRAIN.
- **DRAIN:** one cycle; byte_ready = 0; the final write happens here; load_done = 1 -> RUN.
- **RUN:**
  - core_hold = 0.
  - mem_addr = fetch_addr[ADDR_WIDTH+1:2] combinationally; mem_we = 0.
  - A fetch_req produces one registered response next cycle.
  - Fault condition: fetch_addr[1:0] != 0 or fetch_addr[31:ADDR_WIDTH+2] != 0. On fault, fetch_fault = 1 and fetch_data = 0.
- **Reload:** load_start in RUN -> LOAD, words_loaded cleared. load_start wins over a fetch_req in the same cycle; that fetch gets no response.
- **Ignored inputs:**
  - load_start in LOAD or DRAIN is ignored.
  - fetch_req outside RUN is ignored; fetch_valid stays 0.
- **Partial word:** a stream that stalls mid-word leaves the controller in LOAD indefinitely. There is no timeout.
- **Reset mid-load:** returns to IDLE. Memory keeps whatever words were already written.

## Timing
- **Fetch latency:** 1 cycle. A request at cycle t gives fetch_valid/fetch_data/fetch_fault at t+1. Back-to-back requests are served every cycle.
- **Write latency:** 4th byte accepted at cycle t -> mem_we at t+1.
- **Last word:** mem_we in the DRAIN cycle, together with load_done. The first RUN cycle follows, with core_hold low.
- **No overlap:** write and fetch never share a cycle; mem_we is 0 in RUN.
- **Reload:** the cycle after load_start in RUN has core_hold = 1, byte_ready = 1 and fetch_valid = 0.
- **Words per load:** exactly N words are written; extra stream bytes wait (byte_ready = 0).

## Test plan
- **Load then fetch:**
  - Stimulus: reset, load_start with load_words = 2, then bytes 93 00 A0 00 13 01 40 00 with byte_valid held high.
  - Required:
    - mem_we at word 0 = 0x00A00093, then word 1 = 0x00400113.
    - load_done pulses once; core_hold falls the next cycle.
    - fetch_addr 0x4 gives fetch_data 0x00400113 one cycle later.
- **Gapped stream:** byte_valid toggles every other cycle, with a 5-cycle gap inside word 0. Words are still assembled correctly, and no mem_we occurs before the 4th byte.
- **Fetch faults:**
  - fetch_addr 0x2 -> fetch_fault = 1, data 0.
  - fetch_addr 0x1000 -> fault.
  - fetch_addr 0xFFC -> valid read of word 1023.
- **Edge loads:**
  - load_words = 0 -> DRAIN, load_done, RUN, with no mem_we.
  - load_words = 2000 -> words_loaded stops at 1024.
- **Reload and priority:**
  - Stimulus: in RUN, assert load_start and fetch_req in the same cycle.
  - Required: no fetch_valid, core_hold = 1 next cycle, words_loaded = 0.
- **Reset mid-load:** rst low after 5 bytes. All outputs take their reset values immediately. A new load then starts at word 0 with a clean byte counter.
